// File: rtl/mem_port_arbiter.sv
// Two-port (core, debug/loader) arbiter in front of a single-port memory with fixed access latency.
// Round-robin by default; define ARB_FIXED_PRIO_EN to give the debug port absolute priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       grant_dbg_q;
  logic       any_req;
  logic       pick_dbg;

  assign any_req = core_req | dbg_req;

`ifdef ARB_FIXED_PRIO_EN
  assign pick_dbg = dbg_req;
`else
  // Set when the debug port won the most recent grant; the other port wins the next tie.
  logic last_grant_dbg_q;
  assign pick_dbg = dbg_req & (~core_req | ~last_grant_dbg_q);
`endif

  assign core_stall = core_req & ~core_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      grant_dbg_q <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_dbg_q <= 1'b1;
`endif
      core_ack    <= 1'b0;
      dbg_ack     <= 1'b0;
      core_rdata  <= '0;
      dbg_rdata   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          core_ack <= 1'b0;
          dbg_ack  <= 1'b0;
          if (any_req) begin
            // mem_* registers double as the latched operands of the granted port.
            grant_dbg_q <= pick_dbg;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_dbg_q <= pick_dbg;
`endif
            mem_en    <= 1'b1;
            mem_we    <= pick_dbg ? dbg_we    : core_we;
            mem_addr  <= pick_dbg ? dbg_addr  : core_addr;
            mem_wdata <= pick_dbg ? dbg_wdata : core_wdata;
            cnt_q     <= CntLoad;
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we) begin
              if (grant_dbg_q) dbg_rdata  <= mem_rdata;
              else             core_rdata <= mem_rdata;
            end
            if (grant_dbg_q) dbg_ack  <= 1'b1;
            else             core_ack <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          core_ack <= 1'b0;
          dbg_ack  <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random rounds of core/debug accesses against a
// transaction-level model of arbitration order, memory contents and per-port read data.
module tb_mem_port_arbiter;

  localparam int unsigned W = 3;

  typedef struct {
    int          cyc;
    logic [15:0] rd;
  } ack_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
  } gnt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [15:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_ack, core_stall, dbg_ack;
  logic [15:0] core_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] phys    [256];
  logic [15:0] ref_mem [256];
  logic [15:0] ref_rd  [2];
  bit          ref_last_dbg;

  ack_t cq[$];
  ack_t dq[$];
  gnt_t gq[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  mem_port_arbiter #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_ack  (core_ack),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 257) ^ 16'h5a5a;
  endfunction

  // Memory macro: asynchronous read, write on the clock edge while enabled.
  assign mem_rdata = phys[mem_addr[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) phys[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) phys[mem_addr[7:0]] = mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: apply one access in grant order, queue what the DUT must show.
  task automatic model_op(input bit is_dbg, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input int idle_cyc);
    gnt_t g;
    ack_t a;
    g.cyc = idle_cyc + 1;
    g.we = we;
    g.addr = addr;
    g.wd = wd;
    gq.push_back(g);
    if (we) ref_mem[addr[7:0]] = wd;
    else    ref_rd[is_dbg] = ref_mem[addr[7:0]];
    a.cyc = idle_cyc + int'(W) + 1;
    a.rd = ref_rd[is_dbg];
    if (is_dbg) dq.push_back(a);
    else        cq.push_back(a);
    ref_last_dbg = is_dbg;
  endtask

  task automatic run_port(input bit is_dbg, input int idle_cyc);
    int ack_cyc;
    ack_cyc = idle_cyc + int'(W) + 1;
    while (1) begin
      @(negedge clk);
      // Operands changed after the grant must not reach the memory.
      if (cyc == idle_cyc + 1 && $urandom_range(0, 1) == 1) begin
        if (is_dbg) begin
          dbg_addr = 16'($urandom); dbg_wdata = 16'($urandom); dbg_we = ~dbg_we;
        end else begin
          core_addr = 16'($urandom); core_wdata = 16'($urandom); core_we = ~core_we;
        end
      end
      if (cyc >= ack_cyc) break;
      if (!is_dbg) chk("core_stall_wait", 32'(core_stall), 32'd1);
    end
    if (!is_dbg) chk("core_stall_ack", 32'(core_stall), 32'd0);
    @(posedge clk);
    #1;
    if (is_dbg) dbg_req = 1'b0;
    else        core_req = 1'b0;
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic do_round(input bit dc, input bit dd,
                          input bit cwe, input logic [15:0] ca, input logic [15:0] cw,
                          input bit dwe, input logic [15:0] da, input logic [15:0] dw);
    int g, c_idle, d_idle;
    bit dbg_first;
    g = cyc;
    if (dc && dd) begin
`ifdef ARB_FIXED_PRIO_EN
      dbg_first = 1'b1;
`else
      dbg_first = !ref_last_dbg;
`endif
    end else begin
      dbg_first = dd;
    end
    c_idle = (dc && dd && dbg_first)  ? g + int'(W) + 2 : g;
    d_idle = (dc && dd && !dbg_first) ? g + int'(W) + 2 : g;
    if (dbg_first) begin
      model_op(1'b1, dwe, da, dw, d_idle);
      if (dc) model_op(1'b0, cwe, ca, cw, c_idle);
    end else begin
      if (dc) model_op(1'b0, cwe, ca, cw, c_idle);
      if (dd) model_op(1'b1, dwe, da, dw, d_idle);
    end
    if (dc) begin core_req = 1'b1; core_we = cwe; core_addr = ca; core_wdata = cw; end
    if (dd) begin dbg_req = 1'b1; dbg_we = dwe; dbg_addr = da; dbg_wdata = dw; end
    fork
      begin if (dc) run_port(1'b0, c_idle); end
      begin if (dd) run_port(1'b1, d_idle); end
    join
  endtask

  initial begin : monitor
    ack_t e;
    gnt_t cur;
    bit   act;
    int   run;
    act = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (core_ack) begin
          if (cq.size() == 0) begin
            checks++; errors++;
            $display("FAIL core_ack_unexpected: ack=1 at cycle %0d, expected ack=0", cyc);
          end else begin
            e = cq.pop_front();
            chk("core_ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("core_rdata", 32'(core_rdata), 32'(e.rd));
          end
        end
        if (dbg_ack) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL dbg_ack_unexpected: ack=1 at cycle %0d, expected ack=0", cyc);
          end else begin
            e = dq.pop_front();
            chk("dbg_ack_cycle", 32'(cyc), 32'(e.cyc));
            chk("dbg_rdata", 32'(dbg_rdata), 32'(e.rd));
          end
        end
        if (mem_en) begin
          if (!act) begin
            if (gq.size() == 0) begin
              checks++; errors++;
              $display("FAIL mem_en_unexpected: mem_en=1 at cycle %0d, expected 0", cyc);
              cur.cyc = cyc; cur.we = mem_we; cur.addr = mem_addr; cur.wd = mem_wdata;
            end else begin
              cur = gq.pop_front();
              chk("mem_start_cycle", 32'(cyc), 32'(cur.cyc));
            end
            act = 1'b1;
            run = 0;
          end
          run++;
          chk("mem_we", 32'(mem_we), 32'(cur.we));
          chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
          if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wd));
        end else if (act) begin
          chk("mem_en_cycles", 32'(run), 32'(W));
          act = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    bit dc, dd;
    reset = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    ref_last_dbg = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_core_ack", 32'(core_ack), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    chk("rst_core_rdata", 32'(core_rdata), 32'd0);
    chk("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    chk("rst_core_stall", 32'(core_stall), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Reset in the middle of a write that rewrites the current value, so either outcome is fine.
    @(posedge clk);
    #1;
    core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0005; core_wdata = ref_mem[5];
    @(posedge clk);
    @(negedge clk);
    chk("abort_mem_en_before", 32'(mem_en), 32'd1);
    chk("abort_mem_we_before", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_core_ack", 32'(core_ack), 32'd0);
    chk("abort_dbg_ack", 32'(dbg_ack), 32'd0);
    @(posedge clk);
    #1;
    core_req = 1'b0; core_we = 1'b0;
    @(negedge clk) reset = 1'b0;
    mon_en = 1'b1;
    repeat (2 * W + 4) @(posedge clk);
    #1;

    // First tie after reset, then the directed accesses, then sustained contention.
    do_round(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 16'h0007, 16'h0);
    do_round(1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0004, 16'h1234);
    do_round(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0, 1'b0, 16'h0, 16'h0);
    do_round(1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b1, 16'h0010, 16'hBEEF);
    do_round(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++)
      do_round(1'b1, 1'b1, 1'b0, 16'(i), 16'h0, 1'b0, 16'(i + 16), 16'h0);

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      dc = 1'($urandom_range(0, 1));
      dd = dc ? 1'($urandom_range(0, 1)) : 1'b1;
      do_round(dc, dd,
               1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom),
               1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
    end

    repeat (2 * W + 6) @(posedge clk);
    #1;
    chk("pending_core_acks", 32'(cq.size()), 32'd0);
    chk("pending_dbg_acks", 32'(dq.size()), 32'd0);
    chk("pending_grants", 32'(gq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
